// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch unit: opcode constants,
// instruction field positions, field helpers and the fetch-state enum.
package cpu_pkg;

   localparam logic [7:0] OP_JMP  = 8'h0E;
   localparam logic [7:0] OP_JNE  = 8'h0F;
   localparam logic [7:0] OP_HALT = 8'hFF;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 24;
   localparam int RD_MSB  = 23;
   localparam int RD_LSB  = 20;
   localparam int RS1_MSB = 19;
   localparam int RS1_LSB = 16;
   localparam int RS2_MSB = 15;
   localparam int RS2_LSB = 12;
   localparam int IMM_MSB = 11;
   localparam int IMM_LSB = 0;

   typedef enum logic [1:0] {
      FETCH,
      BR_WAIT,
      HALTED
   } fetch_state_e;

   function automatic logic [7:0] opcode_of(input logic [31:0] word);
      return word[OPC_MSB:OPC_LSB];
   endfunction

   function automatic logic [3:0] rd_of(input logic [31:0] word);
      return word[RD_MSB:RD_LSB];
   endfunction

   function automatic logic [3:0] rs1_of(input logic [31:0] word);
      return word[RS1_MSB:RS1_LSB];
   endfunction

   function automatic logic [3:0] rs2_of(input logic [31:0] word);
      return word[RS2_MSB:RS2_LSB];
   endfunction

   function automatic logic [11:0] imm_of(input logic [31:0] word);
      return word[IMM_MSB:IMM_LSB];
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Program-memory and decode-side signals of the fetch unit, bundled as one interface.
interface instr_fetch_unit_if #(
   parameter int ADDR_W  = 12,
   parameter int INSTR_W = 32
);
   logic [ADDR_W-1:0]  program_addr;
   logic [INSTR_W-1:0] instruction;
   logic [INSTR_W-1:0] instr_out;
   logic               instr_valid;
   logic               instr_ready;
   logic               cond_valid;
   logic               cond_taken;
   logic               halted;

   modport master (
      output program_addr, instr_out, instr_valid, halted,
      input  instruction, instr_ready, cond_valid, cond_taken
   );

   modport slave (
      input  program_addr, instr_out, instr_valid, halted,
      output instruction, instr_ready, cond_valid, cond_taken
   );
endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: sequential increment with wrap, JMP target,
// hold on JNE/HALT capture, and JNE resolution while waiting for the condition.
module fetch_next_pc
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  fetch_state_e      state,
   input  logic              capture,
   input  logic [7:0]        fetch_opcode,
   input  logic [11:0]       fetch_imm,
   input  logic [11:0]       branch_imm,
   input  logic              cond_valid,
   input  logic              cond_taken,
   input  logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] next_pc
);

   logic [ADDR_W-1:0] seq_pc;

   assign seq_pc = pc + ADDR_W'(1);

   // The branch target comes from the held JNE word since nothing is captured in BR_WAIT
   always_comb begin
      next_pc = pc;
      unique case (state)
         FETCH: begin
            if (capture) begin
               if (fetch_opcode == OP_JMP) begin
                  next_pc = ADDR_W'(fetch_imm);
               end else if (fetch_opcode != OP_JNE && fetch_opcode != OP_HALT) begin
                  next_pc = seq_pc;
               end
            end
         end
         BR_WAIT: begin
            if (cond_valid) begin
               next_pc = cond_taken ? ADDR_W'(branch_imm) : seq_pc;
            end
         end
         default: begin
            next_pc = pc;
         end
      endcase
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit with valid/ready output, JMP/JNE/HALT handling.
// Optional feature macro FETCH_PERF_CNT_EN adds a 32-bit fetch_count output.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 12,
   parameter int                INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                 clk_70_mhz,
   input  logic                 reset,
   instr_fetch_unit_if.master   bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]          fetch_count
`endif
);

   fetch_state_e       state;
   fetch_state_e       next_state;
   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  next_pc;
   logic [INSTR_W-1:0] instr_q;
   logic               valid_q;
   logic               capture;
   logic [7:0]         fetch_opcode;

   assign capture      = (state == FETCH) && (!valid_q || bus.instr_ready);
   assign fetch_opcode = opcode_of(bus.instruction[31:0]);

   fetch_next_pc #(
      .ADDR_W (ADDR_W)
   ) u_next_pc (
      .state        (state),
      .capture      (capture),
      .fetch_opcode (fetch_opcode),
      .fetch_imm    (imm_of(bus.instruction[31:0])),
      .branch_imm   (imm_of(instr_q[31:0])),
      .cond_valid   (bus.cond_valid),
      .cond_taken   (bus.cond_taken),
      .pc           (pc),
      .next_pc      (next_pc)
   );

   always_ff @(posedge clk_70_mhz) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         FETCH: begin
            if (capture && fetch_opcode == OP_JNE) begin
               next_state = BR_WAIT;
            end else if (capture && fetch_opcode == OP_HALT) begin
               next_state = HALTED;
            end
         end
         BR_WAIT: begin
            if (bus.cond_valid) begin
               next_state = FETCH;
            end
         end
         HALTED: begin
            next_state = HALTED;
         end
         default: begin
            next_state = FETCH;
         end
      endcase
   end

   // Outside a capture, a completed handshake simply empties the output slot
   always_ff @(posedge clk_70_mhz) begin
      if (reset) begin
         pc      <= RESET_PC;
         instr_q <= '0;
         valid_q <= 1'b0;
      end else begin
         pc <= next_pc;
         if (capture) begin
            instr_q <= bus.instruction;
            valid_q <= 1'b1;
         end else if (valid_q && bus.instr_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk_70_mhz) begin
      if (reset) begin
         fetch_count <= '0;
      end else if (capture) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end
`endif

   assign bus.program_addr = pc;
   assign bus.instr_out    = instr_q;
   assign bus.instr_valid  = valid_q;
   assign bus.halted       = (state == HALTED);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_instr_fetch_unit;

   localparam int ADDR_W   = 12;
   localparam int INSTR_W  = 32;
   localparam int RESET_PC = 0;
   localparam int MEM_SZ   = 4096;

   logic clk;
   logic reset;
   logic [31:0] mem [MEM_SZ];

   instr_fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
`endif

   instr_fetch_unit #(
      .ADDR_W   (ADDR_W),
      .INSTR_W  (INSTR_W),
      .RESET_PC (ADDR_W'(RESET_PC))
   ) dut (
      .clk_70_mhz (clk),
      .reset      (reset),
      .bus        (bus)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count (fetch_count)
`endif
   );

   assign bus.instruction = mem[bus.program_addr];

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model: mode 0 = fetching, 1 = waiting on a branch, 2 = halted
   int          m_pc;
   int          m_mode;
   logic [31:0] m_out;
   bit          m_valid;
   int unsigned m_count;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] randNonCtrl();
      logic [7:0] op;
      do op = 8'($urandom_range(0, 255));
      while (op == 8'h0E || op == 8'h0F || op == 8'hFF);
      return {op, 24'($urandom)};
   endfunction

   function automatic logic [31:0] randAny();
      int r;
      r = $urandom_range(0, 99);
      if (r < 10) return {8'h0E, 12'($urandom), 12'($urandom)};
      if (r < 20) return {8'h0F, 12'($urandom), 12'($urandom)};
      if (r < 22) return {8'hFF, 24'h0};
      return randNonCtrl();
   endfunction

   task automatic modelStep(input bit rst, input bit rdy, input bit cv, input bit ct);
      int          old_mode;
      logic [31:0] w;
      if (rst) begin
         m_pc = RESET_PC; m_mode = 0; m_out = '0; m_valid = 0; m_count = 0;
         return;
      end
      old_mode = m_mode;
      if (old_mode == 0 && (!m_valid || rdy)) begin
         w = mem[m_pc];
         m_out = w;
         m_valid = 1;
         m_count++;
         case (w[31:24])
            8'h0E:   m_pc = int'(w[11:0]);
            8'h0F:   m_mode = 1;
            8'hFF:   m_mode = 2;
            default: m_pc = (m_pc + 1) % MEM_SZ;
         endcase
      end else begin
         if (m_valid && rdy) m_valid = 0;
         if (old_mode == 1 && cv) begin
            m_pc = ct ? int'(m_out[11:0]) : (m_pc + 1) % MEM_SZ;
            m_mode = 0;
         end
      end
   endtask

   task automatic checkOutput();
      cmp("program_addr", 32'(bus.program_addr), 32'(m_pc));
      cmp("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
      cmp("instr_out", bus.instr_out, m_out);
      cmp("halted", 32'(bus.halted), 32'(m_mode == 2));
`ifdef FETCH_PERF_CNT_EN
      cmp("fetch_count", fetch_count, m_count);
`endif
   endtask

   // Called at a falling edge; the DUT and model both step on the next rising edge
   task automatic applyStimulus(input bit rst, input bit rdy, input bit cv, input bit ct);
      reset = rst;
      bus.instr_ready = rdy;
      bus.cond_valid = cv;
      bus.cond_taken = ct;
      @(posedge clk);
      modelStep(rst, rdy, cv, ct);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic steps(input int n, input bit rdy);
      for (int i = 0; i < n; i++) applyStimulus(0, rdy, 0, 0);
   endtask

   initial begin
      clk = 0;
      reset = 1;
      bus.instr_ready = 0;
      bus.cond_valid = 0;
      bus.cond_taken = 0;
      for (int i = 0; i < MEM_SZ; i++) mem[i] = randNonCtrl();
      @(negedge clk);

      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      cmp("reset_pc", 32'(bus.program_addr), 32'd0);
      cmp("reset_valid", 32'(bus.instr_valid), 32'd0);
      cmp("reset_out", bus.instr_out, 32'd0);
      cmp("reset_halted", 32'(bus.halted), 32'd0);

      // Sequential fetch, then JMP to 4092 and wrap past 4095
      mem[0] = 32'h0300_0003;
      mem[1] = 32'h0310_000A;
      mem[10] = 32'h0E00_0FFC;
      steps(1, 1);
      cmp("seq0_out", bus.instr_out, 32'h0300_0003);
      cmp("seq0_pc", 32'(bus.program_addr), 32'd1);
      steps(1, 1);
      cmp("seq1_out", bus.instr_out, 32'h0310_000A);
      cmp("seq1_pc", 32'(bus.program_addr), 32'd2);
      steps(9, 1);
      cmp("jmp_target", 32'(bus.program_addr), 32'd4092);
      steps(4, 1);
      cmp("pc_wrap", 32'(bus.program_addr), 32'd0);

      // JNE at 23 targeting 22, resolved taken then not taken
      mem[0] = 32'h0E00_0017;
      mem[23] = 32'h0F00_2016;
      applyStimulus(1, 0, 0, 0);
      steps(1, 1);
      cmp("jne_reach", 32'(bus.program_addr), 32'd23);
      steps(1, 1);
      cmp("jne_out", bus.instr_out, 32'h0F00_2016);
      steps(2, 1);
      cmp("jne_wait_pc", 32'(bus.program_addr), 32'd23);
      cmp("jne_wait_valid", 32'(bus.instr_valid), 32'd0);
      applyStimulus(0, 1, 1, 1);
      cmp("jne_taken", 32'(bus.program_addr), 32'd22);
      steps(4, 1);
      applyStimulus(0, 1, 1, 0);
      cmp("jne_not_taken", 32'(bus.program_addr), 32'd24);

      // Decode stall for 5 cycles after the first capture
      mem[0] = 32'h0300_0003;
      applyStimulus(1, 0, 0, 0);
      steps(1, 1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, 1, 1);
         cmp("stall_pc", 32'(bus.program_addr), 32'd1);
         cmp("stall_out", bus.instr_out, 32'h0300_0003);
         cmp("stall_valid", 32'(bus.instr_valid), 32'd1);
      end
      steps(1, 1);
      cmp("resume_out", bus.instr_out, 32'h0310_000A);
      cmp("resume_pc", 32'(bus.program_addr), 32'd2);

      // 25-instruction program ending in HALT at 24
      for (int i = 0; i < 24; i++) mem[i] = randNonCtrl();
      mem[24] = 32'hFF00_0000;
      applyStimulus(1, 0, 0, 0);
      steps(25, 1);
      cmp("halt_out", bus.instr_out, 32'hFF00_0000);
      cmp("halt_valid", 32'(bus.instr_valid), 32'd1);
      cmp("halt_flag", 32'(bus.halted), 32'd1);
      cmp("halt_pc", 32'(bus.program_addr), 32'd24);
`ifdef FETCH_PERF_CNT_EN
      cmp("halt_count", fetch_count, 32'd25);
`endif
      steps(2, 0);
      cmp("halt_pending", 32'(bus.instr_valid), 32'd1);
      applyStimulus(0, 1, 1, 1);
      cmp("halt_drain", 32'(bus.instr_valid), 32'd0);
      steps(3, 1);
      cmp("halt_frozen", 32'(bus.program_addr), 32'd24);
      cmp("halt_stays", 32'(bus.halted), 32'd1);
      applyStimulus(1, 1, 0, 0);
      cmp("unhalt_pc", 32'(bus.program_addr), 32'd0);
      cmp("unhalt_flag", 32'(bus.halted), 32'd0);

      // Random programs and handshakes
      for (int i = 0; i < MEM_SZ; i++) mem[i] = randAny();
      applyStimulus(1, 0, 0, 0);
      for (int i = 0; i < 4000; i++) begin
         applyStimulus(($urandom_range(0, 199) == 0) || (m_mode == 2 && $urandom_range(0, 9) == 0),
                       $urandom_range(0, 9) < 7,
                       $urandom_range(0, 3) == 0,
                       1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the program address width.
REQ-002 Parameter INSTR_W, default 32, SHALL set the instruction width.
REQ-003 Parameter RESET_PC, default 0, SHALL set the PC value loaded at reset.
REQ-004 clk_70_mhz  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-006 program_addr  output  ADDR_W  SHALL be the current PC driven to program memory.
REQ-007 instruction  input  INSTR_W  SHALL be the asynchronous-read word for program_addr, valid in the same cycle.
REQ-008 instr_out  output  INSTR_W  SHALL be the registered fetched instruction to decode.
REQ-009 instr_valid  output  1  SHALL flag that instr_out holds an unconsumed instruction.
REQ-010 instr_ready  input  1  SHALL be decode acceptance; transfer occurs when instr_valid && instr_ready.
REQ-011 cond_valid  input  1  SHALL flag that the conditional-jump outcome is present on cond_taken.
REQ-012 cond_taken  input  1  SHALL be 1 when the conditional jump is taken (rs1 != rs2).
REQ-013 halted  output  1  SHALL be high once a halt instruction has been fetched.

Function
REQ-014 Format SHALL be opcode[31:24], rd[23:20], rs1[19:16], rs2[15:12], imm[11:0]; opcodes: JMP 8'h0E, JNE 8'h0F, HALT 8'hFF.
REQ-015 States SHALL be FETCH, BR_WAIT, HALTED.
REQ-016 In FETCH, capture SHALL occur when !instr_valid || instr_ready: instr_out <= instruction, instr_valid <= 1; one-cycle latency from PC to instr_out.
REQ-017 While instr_valid && !instr_ready, instr_out, instr_valid and PC SHALL hold stable.
REQ-018 On capture of a non-control opcode, PC SHALL become PC+1 modulo 2^ADDR_W (4095 wraps to 0).
REQ-019 On capture of JMP, PC SHALL become imm[ADDR_W-1:0]; state stays FETCH.
REQ-020 On capture of JNE, the FSM SHALL enter BR_WAIT with PC held at the JNE address; no capture occurs in BR_WAIT.
REQ-021 In BR_WAIT with cond_valid, PC SHALL become imm if cond_taken, else PC+1 (with wrap); the FSM SHALL return to FETCH.
REQ-022 cond_valid outside BR_WAIT SHALL be ignored.
REQ-023 On capture of HALT, the instruction SHALL be presented, halted SHALL assert the next cycle, and the FSM SHALL enter HALTED.
REQ-024 In HALTED, PC SHALL freeze, no capture occurs, pending instr_valid SHALL drain on instr_ready, and only reset leaves HALTED.
REQ-025 In BR_WAIT and HALTED, a handshake on the held instruction SHALL clear instr_valid.

Reset
REQ-026 On reset: PC=RESET_PC, state=FETCH, instr_out=0, instr_valid=0, halted=0.
REQ-027 Reset SHALL override all activity, including mid-BR_WAIT, HALTED and pending handshakes; the first capture follows in the next cycle.

Configuration
REQ-028 With FETCH_PERF_CNT_EN defined, a 32-bit output fetch_count SHALL reset to 0, increment on each capture, and wrap at 2^32-1.
REQ-029 Without FETCH_PERF_CNT_EN, the fetch_count port and its counter SHALL be absent.

Structure
REQ-030 Package cpu_pkg SHALL hold the opcode constants (OP_JMP, OP_JNE, OP_HALT), the instruction field positions and the fetch-state enum.
REQ-031 Next-PC selection (sequential/JMP/JNE resolution/wrap) SHALL be a combinational sub-module, fetch_next_pc.

Verification
REQ-032 Memory 0:03_0_0_0_003, 1:03_1_0_0_00A with instr_ready=1 -> instr_out equals each word in consecutive cycles, with PC 0,1,2.
REQ-033 Address 10 holds 0E_0_0_0_FFC -> the next capture is from 4092; a non-control word at 4095 -> PC wraps to 0.
REQ-034 JNE 0F_0_0_2_016 at 23, cond_valid asserted 3 cycles later with cond_taken=1 -> no capture while waiting, then PC=22; cond_taken=0 -> PC=24.
REQ-035 instr_ready held low 5 cycles after the first capture -> instr_out/instr_valid/PC stable, then one transfer and fetching resumes.
REQ-036 FF_0_0_0_000 at 24 -> presented once, halted=1 thereafter, PC frozen at 24; reset -> PC=0, halted=0.
REQ-037 With FETCH_PERF_CNT_EN, the 25-instruction program from address 0 -> fetch_count equals the number of captures, including the halt.
